// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider, result = a / b.
// A restoring mantissa divider produces one quotient bit per clock.
// Start/busy/done handshake; flags NAN/INF/DZ/OF/UF.
// Optional macro FPDIV_SATURATE_EN: overflow yields max finite instead of Inf.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold
// DIV   | one restoring quotient bit per cycle, 26 cycles
// NORM  | normalize, round, register result/flags, pulse done
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        NAN,
  output logic        INF,
  output logic        DZ,
  output logic        OF,
  output logic        UF
);

  localparam int QBITS = 26;
  localparam int BIAS  = 127;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;

  logic [1:0]       state;
  logic             sign_q;
  logic [7:0]       ea_q, eb_q;
  logic [23:0]      mb_q;
  logic [24:0]      rem_q;
  logic [QBITS-1:0] quo_q;
  logic [4:0]       cnt_q;
  logic             special_q;
  logic [31:0]      sp_res_q;
  logic             sp_nan_q, sp_inf_q, sp_dz_q;

  // Operand classification (subnormals flushed to zero) and special-case result
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign_in;
  logic        sp_hit, sp_nan, sp_inf, sp_dz;
  logic [31:0] sp_res;

  always_comb begin
    sign_in = a[31] ^ b[31];
    a_nan   = (&a[30:23]) & (|a[22:0]);
    a_inf   = (&a[30:23]) & ~(|a[22:0]);
    a_zero  = (a[30:23] == 8'd0);
    b_nan   = (&b[30:23]) & (|b[22:0]);
    b_inf   = (&b[30:23]) & ~(|b[22:0]);
    b_zero  = (b[30:23] == 8'd0);
    sp_hit  = 1'b1;
    sp_nan  = 1'b0;
    sp_inf  = 1'b0;
    sp_dz   = 1'b0;
    sp_res  = 32'd0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res = 32'h7FC00000;
      sp_nan = 1'b1;
    end else if (a_inf) begin
      sp_res = {sign_in, 8'hFF, 23'd0};
      sp_inf = 1'b1;
    end else if (b_zero) begin
      sp_res = {sign_in, 8'hFF, 23'd0};
      sp_inf = 1'b1;
      sp_dz  = 1'b1;
    end else if (a_zero | b_inf) begin
      sp_res = {sign_in, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring step: compare, conditionally subtract, shift
  logic        q_bit;
  logic [24:0] rem_sub, rem_next;

  always_comb begin
    q_bit    = (rem_q >= {1'b0, mb_q});
    rem_sub  = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_next = rem_sub << 1;
  end

  // Normalize by one position if needed, round to nearest even, range-check exponent
  logic signed [9:0] e_base, e_n, e_r;
  logic [22:0]       mant, mant_r;
  logic [23:0]       mant_inc;
  logic              guard, sticky, round_up, of_n, uf_n;
  logic [31:0]       nrm_res;

  always_comb begin
    e_base = signed'({2'b00, ea_q}) - signed'({2'b00, eb_q}) + signed'(10'(BIAS));
    if (quo_q[QBITS-1]) begin
      mant   = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      e_n    = e_base;
    end else begin
      mant   = quo_q[23:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      e_n    = e_base - 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + 24'd1;
    mant_r   = mant;
    e_r      = e_n;
    if (round_up) begin
      mant_r = mant_inc[22:0];
      if (mant_inc[23]) e_r = e_n + 10'sd1;
    end
    of_n = (e_r >= 10'sd255);
    uf_n = (e_r <= 10'sd0);
    if (of_n) begin
`ifdef FPDIV_SATURATE_EN
      nrm_res = {sign_q, 31'h7F7FFFFF};
`else
      nrm_res = {sign_q, 8'hFF, 23'd0};
`endif
    end else if (uf_n) begin
      nrm_res = {sign_q, 31'd0};
    end else begin
      nrm_res = {sign_q, e_r[7:0], mant_r};
    end
  end

  assign busy = (state != S_IDLE);

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sign_q    <= 1'b0;
      ea_q      <= 8'd0;
      eb_q      <= 8'd0;
      mb_q      <= 24'd0;
      rem_q     <= 25'd0;
      quo_q     <= '0;
      cnt_q     <= 5'd0;
      special_q <= 1'b0;
      sp_res_q  <= 32'd0;
      sp_nan_q  <= 1'b0;
      sp_inf_q  <= 1'b0;
      sp_dz_q   <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      NAN       <= 1'b0;
      INF       <= 1'b0;
      DZ        <= 1'b0;
      OF        <= 1'b0;
      UF        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q    <= sign_in;
            ea_q      <= a[30:23];
            eb_q      <= b[30:23];
            mb_q      <= {1'b1, b[22:0]};
            rem_q     <= {2'b01, a[22:0]};
            quo_q     <= '0;
            cnt_q     <= 5'(QBITS - 1);
            special_q <= sp_hit;
            sp_res_q  <= sp_res;
            sp_nan_q  <= sp_nan;
            sp_inf_q  <= sp_inf;
            sp_dz_q   <= sp_dz;
            NAN       <= 1'b0;
            INF       <= 1'b0;
            DZ        <= 1'b0;
            OF        <= 1'b0;
            UF        <= 1'b0;
            state     <= sp_hit ? S_NORM : S_DIV;
          end
        end
        S_DIV: begin
          quo_q <= {quo_q[QBITS-2:0], q_bit};
          rem_q <= rem_next;
          if (cnt_q == 5'd0) state <= S_NORM;
          else               cnt_q <= cnt_q - 5'd1;
        end
        S_NORM: begin
          if (special_q) begin
            result <= sp_res_q;
            NAN    <= sp_nan_q;
            INF    <= sp_inf_q;
            DZ     <= sp_dz_q;
          end else begin
            result <= nrm_res;
            OF     <= of_n;
            UF     <= uf_n;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq with hand-computed expected values.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, NAN, INF, DZ, OF, UF;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FPDIV_SATURATE_EN
  localparam logic [31:0] OF_RES = 32'h7F7FFFFF;
`else
  localparam logic [31:0] OF_RES = 32'h7F800000;
`endif

  fp_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .NAN(NAN), .INF(INF), .DZ(DZ), .OF(OF), .UF(UF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, NAN, INF, DZ, OF, UF};
  endfunction

  // Issue one operation at the next negedge, then wait (bounded) for done.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] exp_res, input logic [4:0] exp_fl, input int exp_lat);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, flags(), {27'd0, exp_fl});
    check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int dones;
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    @(negedge clk); rst = 1'b0;

    // flags order: {NAN,INF,DZ,OF,UF}
    run_op("div6_2",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27);
    run_op("div1_3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 27);
    // issued in the done cycle of the previous op
    run_op("b2b",     32'hC0F00000, 32'h40200000, 32'hC0400000, 5'b00000, 27);
    run_op("dz",      32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01100, 1);
    run_op("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_op("infinf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1);
    run_op("nan_in",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    run_op("ainf",    32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000, 1);
    run_op("negzero", 32'h80000000, 32'h40A00000, 32'h80000000, 5'b00000, 1);
    run_op("binf",    32'h40A00000, 32'hFF800000, 32'h80000000, 5'b00000, 1);
    run_op("ovf",     32'h7F000000, 32'h3E800000, OF_RES,       5'b00010, 27);
    run_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 5'b00001, 27);
    run_op("div6_2b", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27);

    // Reset in the middle of DIV discards the operation
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("mid_rst_nodone", dones, 0);
    run_op("after_rst", 32'hC0F00000, 32'h40200000, 32'hC0400000, 5'b00000, 27);

    // Start pulsed mid-DIV is ignored
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign_lat", lat, 27);
    check("ign_res", result, 32'h40400000);
    check("ign_flags", flags(), 32'd0);
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("ign_nodone", dones, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
